// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: synchronises and debounces four buttons,
// filters presses against the last intended heading and queues up to two turns.
module snake_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter logic [3:0]  BTN_ACTIVE_LOW  = 4'b0011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       step,
  output logic [1:0] dir,
  output logic [1:0] q_count,
  output logic [3:0] press_pulse,
  output logic       drop
);

  localparam int unsigned CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  logic [3:0] pin;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] sample;

  logic [3:0][CW-1:0] cnt_q;
  logic [3:0][CW-1:0] cnt_d;
  logic [3:0]         stable_q;
  logic [3:0]         stable_d;
  logic [3:0]         rise_d;
  logic [3:0]         pulse_q;

  logic [1:0] dir_q;
  logic [1:0] dir_d;
  logic [1:0] head_q;
  logic [1:0] head_d;
  logic [1:0] tail_q;
  logic [1:0] tail_d;
  logic [1:0] qcnt_q;
  logic [1:0] qcnt_d;
  logic       drop_q;
  logic       drop_d;

  logic       cand_v;
  logic [1:0] cand;
  logic [1:0] last;
  logic       accept;
  logic       pop;
  logic [1:0] mid_cnt;
  logic [1:0] mid_head;
  logic [1:0] mid_tail;

  assign pin = {btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchroniser; idles at each pin's inactive level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= BTN_ACTIVE_LOW;
      sync2_q <= BTN_ACTIVE_LOW;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q ^ BTN_ACTIVE_LOW;

  // Per-button debounce: count disagreeing samples, flip after a full run.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = '0;
    for (int i = 0; i < 4; i++) begin
      if (sample[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]    = '0;
        stable_d[i] = ~stable_q[i];
        rise_d[i]   = ~stable_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounce state and the registered press pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= rise_d;
    end
  end

  // Pick one press per cycle, up has the highest priority.
  always_comb begin
    cand_v = 1'b1;
    cand   = DIR_UP;
    priority case (1'b1)
      pulse_q[0]: cand = DIR_UP;
      pulse_q[1]: cand = DIR_DOWN;
      pulse_q[2]: cand = DIR_LEFT;
      pulse_q[3]: cand = DIR_RIGHT;
      default:    cand_v = 1'b0;
    endcase
  end

  // Compare against the most recent intended heading (pre-pop state).
  always_comb begin
    last = dir_q;
    if (qcnt_q == 2'd2) begin
      last = tail_q;
    end else if (qcnt_q == 2'd1) begin
      last = head_q;
    end
  end

  assign accept = cand_v
                & (cand != last)
                & (cand != (last ^ 2'b01));
  assign pop    = step & (qcnt_q != 2'd0);

  // Queue update: pop first, then push into whatever room is left.
  always_comb begin
    dir_d    = dir_q;
    mid_head = head_q;
    mid_tail = tail_q;
    mid_cnt  = qcnt_q;
    drop_d   = 1'b0;
    if (pop) begin
      dir_d    = head_q;
      mid_head = tail_q;
      mid_tail = '0;
      mid_cnt  = qcnt_q - 2'd1;
    end
    head_d = mid_head;
    tail_d = mid_tail;
    qcnt_d = mid_cnt;
    if (accept) begin
      case (mid_cnt)
        2'd0: begin
          head_d = cand;
          qcnt_d = 2'd1;
        end
        2'd1: begin
          tail_d = cand;
          qcnt_d = 2'd2;
        end
        default: drop_d = 1'b1;
      endcase
    end
  end

  // Committed direction, queue storage and drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q  <= DIR_UP;
      head_q <= '0;
      tail_q <= '0;
      qcnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      head_q <= head_d;
      tail_q <= tail_d;
      qcnt_q <= qcnt_d;
      drop_q <= drop_d;
    end
  end

  assign dir         = dir_q;
  assign q_count     = qcnt_q;
  assign press_pulse = pulse_q;
  assign drop        = drop_q;

endmodule
